pwm_servo_decoder: RTL

PWM_SERVO_DECODER -- requirements
Module: pwm_servo_decoder

---
 rtl/pwm_servo_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_servo_decoder.sv
// pwm_servo_decoder
//   Measures an asynchronous PWM / servo pulse train: high width, rise-to-rise
//   period and duty = floor(high * 2^R / period), saturated to 2^R.
//
//   Ports
//     clk        system clock, all flops on rising edge
//     rst        asynchronous active-low reset
//     pwm_in     asynchronous pulse train
//     duty       last measured duty, R+1 bits
//     high_time  last measured high width in clk cycles
//     period     last measured rise-to-rise period in clk cycles
//     valid      one-cycle strobe when duty/high_time/period update
//     timeout    level, set when no edge is seen for TIMEOUT cycles,
//                cleared by the next valid
//     overrun    one-cycle strobe when a measurement is dropped because the
//                divider is still busy
module pwm_servo_decoder #(
  parameter int unsigned R       = 8,
  parameter int unsigned CW      = 24,
  parameter int unsigned TIMEOUT = 5000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [R:0]    duty,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          timeout,
  output logic          overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(R + 2);
  localparam logic [R:0] DUTY_FULL = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

  state_t        state, state_nxt;
  logic          s1, s2, s3;
  logic          rise, fall;
  logic [CW-1:0] hcnt, hcnt_nxt;
  logic [CW-1:0] pcnt, pcnt_nxt;
  logic [CW-1:0] hi_lat, hi_lat_nxt;
  logic [TW-1:0] idle_cnt;
  logic          idle_hit;
  logic          handoff;

  logic          div_busy;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] div_rem;
  logic [CW-1:0] div_dvsr;
  logic [CW-1:0] div_high;
  logic [R:0]    div_sh;
  logic [R-1:0]  div_q;
  logic          div_sat;
  logic [CW:0]   trial;
  logic [CW:0]   sub;
  logic          q_bit;
  logic [CW-1:0] rem_nxt;
  logic          div_last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Fires on the cycle the edge-free count would reach TIMEOUT.
  assign idle_hit = ~(rise | fall) && (idle_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    pcnt_nxt   = pcnt;
    hi_lat_nxt = hi_lat;
    handoff    = 1'b0;
    case (state)
      ARM: begin
        if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = CW'(1);
          pcnt_nxt  = CW'(1);
        end
      end
      HIGH: begin
        hcnt_nxt = sat_inc(hcnt);
        pcnt_nxt = sat_inc(pcnt);
        if (fall) begin
          hi_lat_nxt = hcnt;
          state_nxt  = LOW;
        end
      end
      LOW: begin
        pcnt_nxt = sat_inc(pcnt);
        if (rise) begin
          handoff   = 1'b1;
          state_nxt = HIGH;
          hcnt_nxt  = CW'(1);
          pcnt_nxt  = CW'(1);
        end
      end
      default: state_nxt = ARM;
    endcase
    if (idle_hit) begin
      state_nxt = ARM;
      hcnt_nxt  = '0;
      pcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= ARM;
      hcnt     <= '0;
      pcnt     <= '0;
      hi_lat   <= '0;
      idle_cnt <= '0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      s3     <= s2;
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      pcnt   <= pcnt_nxt;
      hi_lat <= hi_lat_nxt;
      if (rise | fall)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT))
        idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // Restoring division of (high << R) by period. When high < period the
  // quotient fits R bits, so the remainder starts as high >> 1 (dividend bits
  // above the quotient window) and the remaining R+1 dividend bits, high[0]
  // followed by R zeros, are shifted in one per iteration.
  assign trial    = {div_rem, div_sh[R]};
  assign sub      = trial - {1'b0, div_dvsr};
  assign q_bit    = ~sub[CW];
  assign rem_nxt  = q_bit ? sub[CW-1:0] : trial[CW-1:0];
  assign div_last = div_busy && (div_cnt == DW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy  <= 1'b0;
      div_cnt   <= '0;
      div_rem   <= '0;
      div_dvsr  <= '0;
      div_high  <= '0;
      div_sh    <= '0;
      div_q     <= '0;
      div_sat   <= 1'b0;
      duty      <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= handoff && div_busy;
      if (div_busy) begin
        div_rem <= rem_nxt;
        div_sh  <= {div_sh[R-1:0], 1'b0};
        div_q   <= {div_q[R-2:0], q_bit};
        div_cnt <= div_cnt - DW'(1);
        if (div_last) begin
          div_busy  <= 1'b0;
          valid     <= 1'b1;
          duty      <= div_sat ? DUTY_FULL : {div_q, q_bit};
          high_time <= div_high;
          period    <= div_dvsr;
        end
      end else if (handoff) begin
        // Handoff cycle doubles as the divider load cycle.
        div_busy <= 1'b1;
        div_cnt  <= DW'(R + 1);
        div_rem  <= hi_lat >> 1;
        div_sh   <= {hi_lat[0], {R{1'b0}}};
        div_q    <= '0;
        div_dvsr <= pcnt;
        div_high <= hi_lat;
        div_sat  <= (hi_lat >= pcnt);
      end
      if (idle_hit)
        timeout <= 1'b1;
      else if (div_last)
        timeout <= 1'b0;
    end
  end

endmodule
